// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the two-requester UART transmit arbiter:
// FSM state encoding, requester indices and the default owner-idle timeout.
// The optional owner-idle timeout is enabled by defining ARB_TIMEOUT_EN.
package uart_tx_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN0  = 2'd1;
  localparam logic [1:0] ST_OWN1  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic REQ_IMG  = 1'b0;
  localparam logic REQ_STAT = 1'b1;

  localparam int TIMEOUT_CYCLES_DEFAULT = 4096;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    OWN0  = ST_OWN0,
    OWN1  = ST_OWN1,
    DRAIN = ST_DRAIN
  } arb_state_e;

  // Ownership state that corresponds to a requester index
  function automatic arb_state_e own_state(input logic idx);
    own_state = (idx == REQ_STAT) ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/uart_arb_rr_pick.sv
// Combinational round-robin pick between the image and status requesters.
// On a tie the requester that did not own the UART last is chosen.
module uart_arb_rr_pick
  import uart_tx_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       valid,
  output logic       pick
);

  // Select the winning requester index from the request vector
  always_comb begin
    valid = |req;
    pick  = REQ_IMG;
    case (req)
      2'b01:   pick = REQ_IMG;
      2'b10:   pick = REQ_STAT;
      2'b11:   pick = ~last_owner;
      default: pick = REQ_IMG;
    endcase
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbiter sharing one UART transmitter between an image stream (requester 0)
// and status messages (requester 1). Grants, load strobe, enable, busy and
// the sticky error flag are registered outputs.
// Optional feature: define ARB_TIMEOUT_EN to release an owner that issues no
// load for TIMEOUT_CYCLES cycles.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       r0_req,
  input  logic       r1_req,
  output logic       r0_gnt,
  output logic       r1_gnt,
  input  logic [7:0] r0_tx_data,
  input  logic [7:0] r1_tx_data,
  input  logic       r0_ld,
  input  logic       r1_ld,
  input  logic       r0_done,
  input  logic       r1_done,
  output logic       r0_tx_empty,
  output logic       r1_tx_empty,
  output logic [7:0] tx_data,
  output logic       ld_tx_data,
  output logic       tx_enable,
  input  logic       tx_empty,
  output logic       busy,
  output logic       err
);

  arb_state_e state_r, state_nxt_s;
  logic       last_owner_r, last_owner_nxt_s;
  logic       r0_gnt_r, r1_gnt_r, ld_tx_data_r, tx_enable_r, busy_r, err_r;
  logic [7:0] tx_data_r, load_data_s, own_data_s;
  logic       load_s, err_set_s, timeout_s;
  logic       in_own_s, own_idx_s, own_req_s, own_ld_s, own_done_s, foreign_ld_s;
  logic       pick_valid_s, pick_s;

  // The counter is 16 bits wide, so the timeout must fit in it
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
    $error("uart_tx_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  uart_arb_rr_pick u_rr_pick (
    .req        ({r1_req, r0_req}),
    .last_owner (last_owner_r),
    .valid      (pick_valid_s),
    .pick       (pick_s)
  );

  // Steer the current owner's signals; outside OWN states every ld is foreign
  always_comb begin
    in_own_s     = 1'b0;
    own_idx_s    = REQ_IMG;
    own_req_s    = 1'b0;
    own_ld_s     = 1'b0;
    own_done_s   = 1'b0;
    own_data_s   = 8'h00;
    foreign_ld_s = r0_ld | r1_ld;
    case (state_r)
      OWN0: begin
        in_own_s     = 1'b1;
        own_idx_s    = REQ_IMG;
        own_req_s    = r0_req;
        own_ld_s     = r0_ld;
        own_done_s   = r0_done;
        own_data_s   = r0_tx_data;
        foreign_ld_s = r1_ld;
      end
      OWN1: begin
        in_own_s     = 1'b1;
        own_idx_s    = REQ_STAT;
        own_req_s    = r1_req;
        own_ld_s     = r1_ld;
        own_done_s   = r1_done;
        own_data_s   = r1_tx_data;
        foreign_ld_s = r0_ld;
      end
      default: begin
        in_own_s = 1'b0;
      end
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] idle_cnt_r;

  // Count owner cycles without a load; restart on accepted load or outside OWN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_r <= 16'd0;
    end else if (!in_own_s || (own_ld_s && tx_empty)) begin
      idle_cnt_r <= 16'd0;
    end else if (!own_ld_s) begin
      idle_cnt_r <= idle_cnt_r + 16'd1;
    end else begin
      idle_cnt_r <= idle_cnt_r;
    end
  end

  assign timeout_s = in_own_s && !own_ld_s && (idle_cnt_r == IDLE_LAST);
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state, byte-load and error-event decode
  always_comb begin
    state_nxt_s      = state_r;
    last_owner_nxt_s = last_owner_r;
    load_s           = 1'b0;
    load_data_s      = tx_data_r;
    err_set_s        = foreign_ld_s | timeout_s;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          state_nxt_s = own_state(pick_s);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      OWN0, OWN1: begin
        if (own_ld_s && tx_empty) begin
          load_s      = 1'b1;
          load_data_s = own_data_s;
        end else if (own_ld_s) begin
          err_set_s   = 1'b1;
        end else begin
          load_s      = 1'b0;
        end
        if (own_done_s || !own_req_s || timeout_s) begin
          state_nxt_s      = DRAIN;
          last_owner_nxt_s = own_idx_s;
        end else begin
          state_nxt_s      = state_r;
        end
      end
      DRAIN: begin
        if (tx_empty && !ld_tx_data_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, round-robin history and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_owner_r <= REQ_STAT;
      r0_gnt_r     <= 1'b0;
      r1_gnt_r     <= 1'b0;
      tx_enable_r  <= 1'b0;
      busy_r       <= 1'b0;
      ld_tx_data_r <= 1'b0;
      tx_data_r    <= 8'h00;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      last_owner_r <= last_owner_nxt_s;
      r0_gnt_r     <= (state_nxt_s == OWN0);
      r1_gnt_r     <= (state_nxt_s == OWN1);
      tx_enable_r  <= (state_nxt_s != IDLE);
      busy_r       <= (state_nxt_s != IDLE);
      ld_tx_data_r <= load_s;
      tx_data_r    <= load_data_s;
      err_r        <= err_r | err_set_s;
    end
  end

  assign r0_gnt      = r0_gnt_r;
  assign r1_gnt      = r1_gnt_r;
  assign tx_enable   = tx_enable_r;
  assign busy        = busy_r;
  assign ld_tx_data  = ld_tx_data_r;
  assign tx_data     = tx_data_r;
  assign err         = err_r;
  assign r0_tx_empty = tx_empty & (state_r == OWN0);
  assign r1_tx_empty = tx_empty & (state_r == OWN1);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter. Expected UART bytes are
// queued when a load is driven and compared when ld_tx_data pulses.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       r0_req, r1_req, r0_ld, r1_ld, r0_done, r1_done, tx_empty;
  logic [7:0] r0_tx_data, r1_tx_data;
  logic       r0_gnt, r1_gnt, r0_tx_empty, r1_tx_empty;
  logic [7:0] tx_data;
  logic       ld_tx_data, tx_enable, busy, err;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;

  uart_tx_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .r0_req      (r0_req),
    .r1_req      (r1_req),
    .r0_gnt      (r0_gnt),
    .r1_gnt      (r1_gnt),
    .r0_tx_data  (r0_tx_data),
    .r1_tx_data  (r1_tx_data),
    .r0_ld       (r0_ld),
    .r1_ld       (r1_ld),
    .r0_done     (r0_done),
    .r1_done     (r1_done),
    .r0_tx_empty (r0_tx_empty),
    .r1_tx_empty (r1_tx_empty),
    .tx_data     (tx_data),
    .ld_tx_data  (ld_tx_data),
    .tx_enable   (tx_enable),
    .tx_empty    (tx_empty),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string p);
    chk({p, "_r0_gnt"}, {7'd0, r0_gnt}, 8'd0);
    chk({p, "_r1_gnt"}, {7'd0, r1_gnt}, 8'd0);
    chk({p, "_ld"}, {7'd0, ld_tx_data}, 8'd0);
    chk({p, "_txen"}, {7'd0, tx_enable}, 8'd0);
    chk({p, "_txdata"}, tx_data, 8'h00);
    chk({p, "_err"}, {7'd0, err}, 8'd0);
    chk({p, "_busy"}, {7'd0, busy}, 8'd0);
    chk({p, "_r0_empty"}, {7'd0, r0_tx_empty}, 8'd0);
  endtask

  task automatic reset_dut(input string p);
    rst_n = 1'b0;
    r0_req = 1'b0; r1_req = 1'b0; r0_ld = 1'b0; r1_ld = 1'b0;
    r0_done = 1'b0; r1_done = 1'b0; tx_empty = 1'b1;
    r0_tx_data = 8'h00; r1_tx_data = 8'h00;
    tick();
    tick();
    check_reset_vals(p);
    rst_n = 1'b1;
  endtask

  // Scoreboard: every ld_tx_data pulse must match the oldest queued byte
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ld_tx_data === 1'b1) begin
      chk("ld_expected", {7'd0, ld_tx_data}, {7'd0, exp_q.size() > 0});
      if (exp_q.size() > 0) begin
        exp_byte = exp_q.pop_front();
        chk("sb_tx_data", tx_data, exp_byte);
      end
    end
  end

  // Guard against a stalled run
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    reset_dut("rst0");

    // Single requester: grant after one cycle, five loads in order
    r0_req = 1'b1;
    tick();
    chk("g0_r0_gnt", {7'd0, r0_gnt}, 8'd1);
    chk("g0_r1_gnt", {7'd0, r1_gnt}, 8'd0);
    chk("g0_txen", {7'd0, tx_enable}, 8'd1);
    chk("g0_busy", {7'd0, busy}, 8'd1);
    chk("g0_r0_empty", {7'd0, r0_tx_empty}, 8'd1);
    chk("g0_r1_empty", {7'd0, r1_tx_empty}, 8'd0);
    for (int i = 0; i < 5; i++) begin
      r0_tx_data = 8'h11 + 8'(i);
      r0_ld = 1'b1;
      exp_q.push_back(r0_tx_data);
      tick();
    end
    r0_ld = 1'b0;
    r0_done = 1'b1;
    tick();
    r0_done = 1'b0;
    r0_req = 1'b0;
    chk("done_gnt_drop", {7'd0, r0_gnt}, 8'd0);
    chk("drain_busy", {7'd0, busy}, 8'd1);
    tick();
    chk("idle_busy", {7'd0, busy}, 8'd0);
    chk("idle_txen", {7'd0, tx_enable}, 8'd0);
    chk("no_err", {7'd0, err}, 8'd0);
    chk("hold_txdata", tx_data, 8'h15);

    // Tie after reset goes to r0, then alternation
    reset_dut("rst1");
    r0_req = 1'b1;
    r1_req = 1'b1;
    tick();
    chk("tie_r0_gnt", {7'd0, r0_gnt}, 8'd1);
    chk("tie_r1_gnt", {7'd0, r1_gnt}, 8'd0);
    r0_done = 1'b1;
    tick();
    r0_done = 1'b0;
    r0_req = 1'b0;
    chk("drain_pend_r1", {7'd0, r1_gnt}, 8'd0);
    tick();
    chk("idle_pend_r1", {7'd0, r1_gnt}, 8'd0);
    tick();
    chk("rr_r1_gnt", {7'd0, r1_gnt}, 8'd1);
    chk("rr_r1_empty", {7'd0, r1_tx_empty}, 8'd1);
    chk("rr_r0_empty", {7'd0, r0_tx_empty}, 8'd0);
    r1_req = 1'b0;
    tick();
    chk("reqfall_drop", {7'd0, r1_gnt}, 8'd0);
    r0_req = 1'b1;
    r1_req = 1'b1;
    tick();
    chk("rereq_idle", {6'd0, r1_gnt, r0_gnt}, 8'd0);
    tick();
    chk("alt_r0_gnt", {7'd0, r0_gnt}, 8'd1);
    chk("alt_r1_gnt", {7'd0, r1_gnt}, 8'd0);

    // Hand over to r1, then a foreign ld from r0
    r0_done = 1'b1;
    tick();
    r0_done = 1'b0;
    r0_req = 1'b0;
    tick();
    tick();
    chk("own1_gnt", {7'd0, r1_gnt}, 8'd1);
    chk("own1_err0", {7'd0, err}, 8'd0);
    r0_tx_data = 8'hAA;
    r0_ld = 1'b1;
    tick();
    r0_ld = 1'b0;
    chk("foreign_no_ld", {7'd0, ld_tx_data}, 8'd0);
    chk("foreign_err", {7'd0, err}, 8'd1);
    chk("foreign_txdata", tx_data, 8'h00);
    r1_tx_data = 8'h5A;
    r1_ld = 1'b1;
    exp_q.push_back(8'h5A);
    tick();
    r1_ld = 1'b0;
    tick();
    tick();
    chk("hold_5a", tx_data, 8'h5A);
    chk("hold_no_ld", {7'd0, ld_tx_data}, 8'd0);

    // Done and ld in the same cycle: byte issued, DRAIN waits for the pulse
    r1_tx_data = 8'hC3;
    r1_ld = 1'b1;
    r1_done = 1'b1;
    exp_q.push_back(8'hC3);
    tick();
    r1_ld = 1'b0;
    r1_done = 1'b0;
    r1_req = 1'b0;
    chk("dl_gnt_drop", {7'd0, r1_gnt}, 8'd0);
    chk("dl_ld", {7'd0, ld_tx_data}, 8'd1);
    chk("dl_busy_a", {7'd0, busy}, 8'd1);
    tick();
    chk("dl_busy_b", {7'd0, busy}, 8'd1);
    tick();
    chk("dl_idle", {7'd0, busy}, 8'd0);

    // Load while transmitter busy is dropped; DRAIN waits for tx_empty
    reset_dut("rst2");
    r0_req = 1'b1;
    tick();
    tx_empty = 1'b0;
    #1;
    chk("busy_r0_empty", {7'd0, r0_tx_empty}, 8'd0);
    r0_tx_data = 8'h77;
    r0_ld = 1'b1;
    tick();
    r0_ld = 1'b0;
    chk("drop_no_ld", {7'd0, ld_tx_data}, 8'd0);
    chk("drop_err", {7'd0, err}, 8'd1);
    r0_done = 1'b1;
    r1_req = 1'b1;
    tick();
    r0_done = 1'b0;
    r0_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("drain_wait_busy", {7'd0, busy}, 8'd1);
      chk("drain_wait_gnt", {6'd0, r1_gnt, r0_gnt}, 8'd0);
      tick();
    end
    tx_empty = 1'b1;
    chk("drain_still", {7'd0, busy}, 8'd1);
    tick();
    chk("drain_exit", {7'd0, busy}, 8'd0);
    tick();
    chk("pend_r1_gnt", {7'd0, r1_gnt}, 8'd1);
    chk("drop_txdata", tx_data, 8'h00);
    r1_req = 1'b0;
    tick();
    tick();

    // Asynchronous reset with a load in flight
    r0_req = 1'b1;
    tick();
    chk("pre_rst_gnt", {7'd0, r0_gnt}, 8'd1);
    r0_tx_data = 8'hE1;
    r0_ld = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("arst");
    r0_ld = 1'b0;
    r0_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_ld", {7'd0, ld_tx_data}, 8'd0);
      chk("post_rst_busy", {7'd0, busy}, 8'd0);
    end

`ifdef ARB_TIMEOUT_EN
    // Owner idle for TIMEOUT_CYCLES is forced out; pending r1 then wins
    reset_dut("rst3");
    r0_req = 1'b1;
    r1_req = 1'b1;
    tick();
    chk("to_gnt_c1", {7'd0, r0_gnt}, 8'd1);
    for (int c = 2; c <= 16; c++) begin
      tick();
      chk("to_gnt_hold", {7'd0, r0_gnt}, 8'd1);
    end
    tick();
    chk("to_gnt_drop", {7'd0, r0_gnt}, 8'd0);
    chk("to_err", {7'd0, err}, 8'd1);
    chk("to_busy", {7'd0, busy}, 8'd1);
    tick();
    tick();
    chk("to_r1_gnt", {7'd0, r1_gnt}, 8'd1);
    chk("to_r0_gnt", {7'd0, r0_gnt}, 8'd0);
`endif

    chk("sb_drained", 8'(exp_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
